// File: rtl/next_sequencer.sv
// next_sequencer: instruction fetch / next-address control FSM for the Forth core.
// Define NEXT_SEQ_FAST_EN to let SEQ and 0BRANCH skip EXEC (3-cycle instructions).
module next_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int OPC_MSB    = 15
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [DATA_WIDTH-1:0] instrucao,
    input  logic                  memAck,
    input  logic                  stall,
    input  logic                  tosZero,
    input  logic                  rsEmpty,
    input  logic                  rsFull,
    output logic                  memReq,
    output logic [1:0]            selectNEXT,
    output logic                  torSelect,
    output logic                  pcLoad,
    output logic                  rPush,
    output logic                  rPop,
    output logic                  fault
);

`ifdef NEXT_SEQ_FAST_EN
    localparam bit FAST_PATH = 1'b1;
`else
    localparam bit FAST_PATH = 1'b0;
`endif

    localparam logic [1:0] CLS_SEQ  = 2'b00;
    localparam logic [1:0] CLS_ZBR  = 2'b01;
    localparam logic [1:0] CLS_CALL = 2'b10;

    localparam logic [1:0] SEL_POP = 2'b00;
    localparam logic [1:0] SEL_TOR = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b11;

    typedef enum logic [2:0] {
        sRst, sFetch, sDecode, sExec, sUpdate, sFault
    } seqStateT;

    seqStateT              state;
    seqStateT              stateNext;
    logic [1:0]            selNext;
    logic                  torNext;
    logic [DATA_WIDTH-1:0] ir;
    logic [1:0]            opClass;
    logic                  unusedIrBits;

    assign opClass      = ir[OPC_MSB:OPC_MSB-1];
    // Operand bits belong to the datapath; only the class field steers sequencing.
    assign unusedIrBits = ^ir;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state      <= sRst;
            selectNEXT <= SEL_TOR;
            torSelect  <= 1'b0;
        end else begin
            state      <= stateNext;
            selectNEXT <= selNext;
            torSelect  <= torNext;
        end
    end

    // A reset edge must never capture the word that was being acknowledged.
    always_ff @(posedge clock) begin
        if (resetN && !stall && state == sFetch && memAck) begin
            ir <= instrucao;
        end
    end

    always_comb begin
        stateNext = state;
        selNext   = SEL_TOR;
        torNext   = 1'b0;
        memReq    = 1'b0;
        pcLoad    = 1'b0;
        rPush     = 1'b0;
        rPop      = 1'b0;
        fault     = 1'b0;

        case (state)
            sRst: stateNext = sFetch;
            sFetch: begin
                memReq = 1'b1;
                if (memAck) begin
                    stateNext = sDecode;
                end
            end
            sDecode: begin
                case (opClass)
                    CLS_SEQ: begin
                        stateNext = FAST_PATH ? sUpdate : sExec;
                    end
                    CLS_ZBR: begin
                        torNext   = tosZero;
                        stateNext = FAST_PATH ? sUpdate : sExec;
                    end
                    CLS_CALL: begin
                        selNext   = SEL_MEM;
                        stateNext = rsFull ? sFault : sExec;
                    end
                    default: begin
                        selNext   = SEL_POP;
                        stateNext = rsEmpty ? sFault : sExec;
                    end
                endcase
                // A faulting instruction never presents its next-address select.
                if (stateNext == sFault) begin
                    selNext = SEL_TOR;
                    torNext = 1'b0;
                end
            end
            sExec: begin
                rPush     = (opClass == CLS_CALL);
                rPop      = (opClass != CLS_CALL) && opClass[1];
                selNext   = selectNEXT;
                torNext   = torSelect;
                stateNext = sUpdate;
            end
            sUpdate: begin
                pcLoad    = 1'b1;
                stateNext = sFetch;
            end
            sFault: begin
                fault     = 1'b1;
                stateNext = sFault;
            end
            default: stateNext = sRst;
        endcase

        // Stall freezes the sequencer; Moore strobes therefore stay asserted.
        if (stall) begin
            stateNext = state;
            selNext   = selectNEXT;
            torNext   = torSelect;
        end
    end

endmodule

// File: tb/tb_next_sequencer.sv
// Directed bench for next_sequencer: per-instruction expected output traces plus literal latency pins.
module tb_next_sequencer;

`ifdef NEXT_SEQ_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetN;
    logic [15:0] instrucao;
    logic        memAck;
    logic        stall;
    logic        tosZero;
    logic        rsEmpty;
    logic        rsFull;
    logic        memReq;
    logic [1:0]  selectNEXT;
    logic        torSelect;
    logic        pcLoad;
    logic        rPush;
    logic        rPop;
    logic        fault;

    next_sequencer #(.DATA_WIDTH(16), .OPC_MSB(15)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .instrucao  (instrucao),
        .memAck     (memAck),
        .stall      (stall),
        .tosZero    (tosZero),
        .rsEmpty    (rsEmpty),
        .rsFull     (rsFull),
        .memReq     (memReq),
        .selectNEXT (selectNEXT),
        .torSelect  (torSelect),
        .pcLoad     (pcLoad),
        .rPush      (rPush),
        .rPop       (rPop),
        .fault      (fault)
    );

    always #5 clock = ~clock;

    int nCompared = 0;
    int nMismatch = 0;

    // {check, memReq, selectNEXT[1:0], torSelect, pcLoad, rPush, rPop, fault}
    logic [8:0] expQ[$];
    logic [8:0] ent;
    int cycNo = 0;
    int fetchStart = 0;
    int latency = 0;
    int pcCount = 0;
    int rPopCycles = 0;
    logic prevMemReq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ev(input bit mr, input logic [1:0] s, input bit t,
                                      input bit pl, input bit pu, input bit po, input bit f);
        return {mr, s, t, pl, pu, po, f};
    endfunction

    localparam logic [7:0] IDLE_E  = 8'b0_01_0_0_0_0_0;
    localparam logic [7:0] FETCH_E = 8'b1_01_0_0_0_0_0;
    localparam logic [7:0] FAULT_E = 8'b0_01_0_0_0_0_1;

    always @(negedge clock) begin
        cycNo++;
        if (expQ.size() > 0) begin
            ent = expQ.pop_front();
            if (ent[8]) begin
                chk($sformatf("cyc%0d_outputs", cycNo),
                    {24'd0, memReq, selectNEXT, torSelect, pcLoad, rPush, rPop, fault},
                    {24'd0, ent[7:0]});
            end
        end
        if (memReq && !prevMemReq) fetchStart = cycNo;
        if (pcLoad && !stall) begin
            latency = cycNo - fetchStart + 1;
            pcCount++;
        end
        if (rPop) rPopCycles++;
        prevMemReq = memReq;
    end

    task automatic tick(input logic [7:0] e, input bit doCheck);
        expQ.push_back({doCheck, e});
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        stall  = 1'b0;
        memAck = 1'b0;
        tick(IDLE_E, 1'b0);
        resetN = 1'b1;
        tick(IDLE_E, 1'b1);
    endtask

    // Drives one instruction starting in a FETCH cycle and queues the cycle-by-cycle
    // outputs implied by the instruction-level rules.
    task automatic runInstr(input logic [15:0] w, input int waits, input int fetchStall,
                            input bit tz, input bit full, input bit empty, input int execStall);
        logic [1:0] cls;
        logic [1:0] sel;
        bit         tor;
        cls = w[15:14];
        for (int i = 0; i < fetchStall; i++) begin
            stall = 1'b1; memAck = 1'b1; instrucao = 16'hC000;
            tick(FETCH_E, 1'b1);
        end
        stall = 1'b0;
        for (int i = 0; i < waits; i++) begin
            memAck = 1'b0; instrucao = 16'($urandom);
            tick(FETCH_E, 1'b1);
        end
        memAck = 1'b1; instrucao = w;
        tick(FETCH_E, 1'b1);
        instrucao = 16'($urandom);
        tosZero = tz; rsFull = full; rsEmpty = empty;
        tick(IDLE_E, 1'b1);
        tosZero = !tz; rsFull = 1'b0; rsEmpty = 1'b0;
        if ((cls == 2'b10 && full) || (cls == 2'b11 && empty)) begin
            for (int i = 0; i < 4; i++) begin
                memAck = i[0]; tosZero = i[1];
                tick(FAULT_E, 1'b1);
            end
            memAck = 1'b0;
            return;
        end
        sel = (cls == 2'b10) ? 2'b11 : (cls == 2'b11) ? 2'b00 : 2'b01;
        tor = (cls == 2'b01) && tz;
        if (!(FAST && cls[1] == 1'b0)) begin
            for (int i = 0; i <= execStall; i++) begin
                stall = (i < execStall);
                tick(ev(1'b0, sel, tor, 1'b0, cls == 2'b10, cls == 2'b11, 1'b0), 1'b1);
            end
        end
        stall = 1'b0; memAck = 1'b0;
        tick(ev(1'b0, sel, tor, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int popBefore;
        resetN = 1'b0; instrucao = 16'h0; memAck = 1'b0; stall = 1'b0;
        tosZero = 1'b0; rsEmpty = 1'b0; rsFull = 1'b0;
        @(posedge clock);
        #1;
        doReset();

        // Reset during a fetch, with an ack and a stall present on the same edge.
        memAck = 1'b0;
        tick(FETCH_E, 1'b1);
        resetN = 1'b0; memAck = 1'b1; stall = 1'b1; instrucao = 16'hC000;
        tick(FETCH_E, 1'b1);
        resetN = 1'b1; stall = 1'b0; memAck = 1'b0;
        tick(IDLE_E, 1'b1);

        runInstr(16'h0005, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("seqLatency", latency, FAST ? 32'd3 : 32'd4);
        runInstr(16'h4020, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        runInstr(16'h4020, 1, 0, 1'b0, 1'b0, 1'b0, 0);
        runInstr(16'h8123, 2, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("callLatency", latency, 32'd6);
        popBefore = rPopCycles;
        runInstr(16'hC000, 0, 2, 1'b0, 1'b0, 1'b0, 3);
        chk("retPopCycles", rPopCycles - popBefore, 32'd4);

        runInstr(16'h8123, 0, 0, 1'b0, 1'b1, 1'b0, 0);
        doReset();
        popBefore = rPopCycles;
        runInstr(16'hC000, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        chk("faultNoPop", rPopCycles - popBefore, 32'd0);
        doReset();
        runInstr(16'h0005, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        chk("pcLoadCount", pcCount, 32'd6);

        @(negedge clock);
        chk("queueDrained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/next_sequencer.md
Name: next_sequencer

Overview:
- Control FSM that sequences instruction fetch and next-address selection for the Forth core.
- Drives the 2-bit `selectNEXT` code and the torNEXT sub-mux select.
- Handshakes with program memory and issues push/pop strobes to the return stack.
- Owns no PC storage. It asserts `pcLoad` when the selected next address is valid.

Parameters:
- DATA_WIDTH, 16, instruction/address width.
- OPC_MSB, 15, MSB of the 2-bit opcode class field `instrucao[OPC_MSB:OPC_MSB-1]`.

Ports:
- clock  in  1  system clock, all state on rising edge.
- resetN  in  1  synchronous, active-low reset, sampled on rising edge of clock.
- instrucao  in  DATA_WIDTH  instruction word from program memory, valid when memAck=1.
- memAck  in  1  program memory data-valid.
- stall  in  1  freeze FSM in current state; outputs hold.
- tosZero  in  1  data stack top equals zero (0BRANCH condition).
- rsEmpty  in  1  return stack empty.
- rsFull  in  1  return stack full.
- memReq  out  1  fetch request to program memory.
- selectNEXT  out  2  next-address select: 00 = pop from stack, 01 = torNEXT result, 11 = program-memory address.
- torSelect  out  1  torNEXT sub-mux: 0 = PC+1, 1 = branch target.
- pcLoad  out  1  one-cycle PC write strobe.
- rPush  out  1  one-cycle return-stack push (return address PC+1).
- rPop  out  1  one-cycle return-stack pop.
- fault  out  1  sticky stack-fault flag.

Behaviour:
- Reset (resetN=0 at clock edge): state=RST; outputs memReq=0, selectNEXT=01, torSelect=0, pcLoad=0, rPush=0, rPop=0, fault=0. Reset is honoured in any state, including mid-fetch. A pending memAck is ignored.
- States: RST, FETCH, DECODE, EXEC, UPDATE, FAULT. Encoding is free.
- RST -> FETCH on the first cycle with resetN=1.
- FETCH:
  - memReq=1 is held until memAck=1.
  - `instrucao` is latched into an internal IR on that same edge.
  - Next state is DECODE.
  - memAck while not in FETCH is ignored.
- DECODE: class = IR[OPC_MSB:OPC_MSB-1].
  - 00 SEQ: selectNEXT=01, torSelect=0.
  - 01 0BRANCH: selectNEXT=01, torSelect=tosZero, sampled in DECODE.
  - 10 CALL: selectNEXT=11. If rsFull, go to FAULT.
  - 11 RET: selectNEXT=00. If rsEmpty, go to FAULT.
  - Otherwise go to EXEC.
- EXEC:
  - CALL: rPush=1 for exactly one cycle.
  - RET: rPop=1 for exactly one cycle.
  - SEQ/0BRANCH: no strobe.
  - Next state is UPDATE.
- UPDATE: pcLoad=1 for exactly one cycle, selectNEXT/torSelect stable. Next state is FETCH.
- selectNEXT/torSelect are registered. They are set in DECODE and held unchanged through EXEC and UPDATE. Outside those states they return to 01/0.
- FAULT:
  - fault=1, all strobes 0, memReq=0.
  - Exit only by reset.
  - No pcLoad is issued for the faulting instruction.
- stall=1:
  - The state register and all registered outputs hold.
  - A one-cycle strobe (pcLoad/rPush/rPop) stays high for the whole stall and issues exactly once in effect. Consumers must qualify it with !stall.
  - In FETCH, memReq stays 1 and memAck is ignored while stall=1.
- stall and resetN=0 together: reset wins.
- Latency with zero-wait memory: 4 cycles per instruction (FETCH, DECODE, EXEC, UPDATE). Each memory wait cycle adds 1.
- selectNEXT is never driven to 10.

Optional Feature:
- Macro: NEXT_SEQ_FAST_EN.
- Defined: SEQ and 0BRANCH classes skip EXEC, going DECODE -> UPDATE, for 3 cycles per instruction. CALL/RET are unchanged.
- Not defined: all classes pass through EXEC, for 4 cycles per instruction.

Test Plan:
- Reset mid-FETCH (memReq=1, assert resetN=0 for 1 cycle with memAck=1) -> next cycle all outputs at reset values; fetch restarts; IR not loaded from the ignored ack.
- SEQ 0x0005, memAck at first FETCH cycle -> selectNEXT=01, torSelect=0, pcLoad pulse 4 cycles after FETCH entry (3 with NEXT_SEQ_FAST_EN); no rPush/rPop.
- 0BRANCH 0x4020 with tosZero=1, then again with tosZero=0 -> torSelect=1 then 0, selectNEXT=01 both, one pcLoad each.
- CALL 0x8123 with rsFull=0 and 2 memAck wait cycles -> selectNEXT=11, rPush one cycle in EXEC, pcLoad next cycle; total 6 cycles.
- RET 0xC000 with rsEmpty=1 -> FAULT; fault=1 sticky; no pcLoad, no rPop, memReq=0 until reset.
- RET with rsEmpty=0 and stall=1 for 3 cycles during EXEC -> rPop held high 4 cycles, state held; UPDATE follows with selectNEXT=00 and a single pcLoad.
